// File: rtl/bsg_manycore_link_traffic_gen.sv
// Manycore-link traffic generator: issues N remote stores then N remote loads to one tile,
// tracks endpoint credits, and checks every return in order against the expected data.
module bsg_manycore_link_traffic_gen
    #(parameter int unsigned addr_width_p      = 28
    , parameter int unsigned data_width_p      = 32
    , parameter int unsigned x_cord_width_p    = 7
    , parameter int unsigned y_cord_width_p    = 7
    , parameter int unsigned max_out_credits_p = 16
    , parameter int unsigned count_width_p     = 16
    , localparam int unsigned packet_width_lp  = addr_width_p + 4 + 5 + data_width_p
                                                 + 2*x_cord_width_p + 2*y_cord_width_p
    , localparam int unsigned return_width_lp  = 2 + data_width_p + 5 + x_cord_width_p + y_cord_width_p
    , localparam int unsigned link_sif_width_lp = packet_width_lp + return_width_lp + 4
    , localparam int unsigned credit_width_lp  = $clog2(max_out_credits_p + 1)
    )
    (input  logic                         clk_i
    , input  logic                         reset_i
    , input  logic [link_sif_width_lp-1:0] link_sif_i
    , output logic [link_sif_width_lp-1:0] link_sif_o
    , input  logic [x_cord_width_p-1:0]    my_x_i
    , input  logic [y_cord_width_p-1:0]    my_y_i
    , input  logic [x_cord_width_p-1:0]    dest_x_i
    , input  logic [y_cord_width_p-1:0]    dest_y_i
    , input  logic                         start_i
    , input  logic [count_width_p-1:0]     num_pkts_i
    , input  logic [addr_width_p-1:0]      base_addr_i
    , input  logic [data_width_p-1:0]      seed_i
    , output logic                         busy_o
    , output logic                         done_o
    , output logic [count_width_p-1:0]     error_count_o
    , output logic [credit_width_lp-1:0]   credits_o
    );

    typedef enum logic [3:0] {e_remote_load = 4'd0, e_remote_store = 4'd1} op_e;
    typedef enum logic [1:0] {e_return_credit = 2'd0, e_return_int_wb = 2'd1} ret_type_e;
    typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, DONE} state_e;

    typedef struct packed {
        logic [addr_width_p-1:0]   addr;
        logic [3:0]                op;
        logic [4:0]                reg_id;
        logic [data_width_p-1:0]   payload;
        logic [y_cord_width_p-1:0] src_y_cord;
        logic [x_cord_width_p-1:0] src_x_cord;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } packet_s;

    typedef struct packed {
        logic [1:0]                pkt_type;
        logic [data_width_p-1:0]   data;
        logic [4:0]                reg_id;
        logic [y_cord_width_p-1:0] y_cord;
        logic [x_cord_width_p-1:0] x_cord;
    } return_packet_s;

    typedef struct packed {
        logic    v;
        packet_s data;
        logic    ready_and_rev;
    } fwd_link_s;

    typedef struct packed {
        logic           v;
        return_packet_s data;
        logic           ready_and_rev;
    } rev_link_s;

    typedef struct packed {
        fwd_link_s fwd;
        rev_link_s rev;
    } link_sif_s;

    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    state_e                     state_q, state_d;
    logic [count_width_p-1:0]   n_q, n_d;
    logic [addr_width_p-1:0]    base_q, base_d;
    logic [data_width_p-1:0]    seed_q, seed_d;
    logic [count_width_p-1:0]   idx_q, idx_d;
    logic [count_width_p-1:0]   st_ret_q, st_ret_d;
    logic [count_width_p-1:0]   ld_ret_q, ld_ret_d;
    logic [credit_width_lp-1:0] credits_q, credits_d;
    logic [count_width_p-1:0]   err_q, err_d;

    link_sif_s link_in, link_out;
    packet_s   pkt;
    logic      in_rdy, fwd_v, send, ret_hs, fwd_in_hs, last_send, at_max, stray_ret, ret_err;
    logic [1:0]             err_inc;
    logic [count_width_p:0] err_sum;
    logic                   unused_inputs;

    assign link_in   = link_sif_i;
    assign in_rdy    = ~reset_i;
    assign fwd_v     = in_rdy & ((state_q == STORE) | (state_q == LOAD)) & (credits_q != '0);
    assign send      = fwd_v & link_in.fwd.ready_and_rev;
    assign ret_hs    = link_in.rev.v & in_rdy;
    assign fwd_in_hs = link_in.fwd.v & in_rdy;
    assign last_send = (idx_q == n_q - count_width_p'(1));
    assign at_max    = (credits_q == max_credits_lp);
    // A return with nothing outstanding cannot be matched to a request.
    assign stray_ret = ret_hs & at_max & ~send;

    assign unused_inputs = ^{link_in.rev.ready_and_rev, link_in.fwd.data,
                             link_in.rev.data.x_cord, link_in.rev.data.y_cord};

    always_comb begin
        credits_d = credits_q;
        if (send && !ret_hs)
            credits_d = credits_q - credit_width_lp'(1);
        else if (ret_hs && !send && !at_max)
            credits_d = credits_q + credit_width_lp'(1);
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        base_d   = base_q;
        seed_d   = seed_q;
        idx_d    = idx_q;
        st_ret_d = st_ret_q;
        ld_ret_d = ld_ret_q;
        ret_err  = 1'b0;

        // Returns arrive in issue order: all store credits first, then load write-backs.
        if (ret_hs) begin
            if (stray_ret) begin
                ret_err = 1'b1;
            end else if (st_ret_q < n_q) begin
                ret_err  = (link_in.rev.data.pkt_type != e_return_credit);
                st_ret_d = st_ret_q + count_width_p'(1);
            end else begin
                ret_err  = (link_in.rev.data.pkt_type != e_return_int_wb)
                         | (link_in.rev.data.data != seed_q + data_width_p'(ld_ret_q))
                         | (link_in.rev.data.reg_id != 5'(ld_ret_q));
                ld_ret_d = ld_ret_q + count_width_p'(1);
            end
        end

        err_inc = {1'b0, ret_err} + {1'b0, fwd_in_hs};
        err_sum = {1'b0, err_q} + (count_width_p+1)'(err_inc);
        err_d   = err_sum[count_width_p] ? '1 : err_sum[count_width_p-1:0];

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    n_d      = num_pkts_i;
                    base_d   = base_addr_i;
                    seed_d   = seed_i;
                    idx_d    = '0;
                    st_ret_d = '0;
                    ld_ret_d = '0;
                    err_d    = '0;
                    state_d  = (num_pkts_i == '0) ? DONE : STORE;
                end
            end
            STORE: begin
                if (send) begin
                    if (last_send) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d = idx_q + count_width_p'(1);
                    end
                end
            end
            LOAD: begin
                if (send) begin
                    if (last_send) begin
                        idx_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + count_width_p'(1);
                    end
                end
            end
            DRAIN: begin
                if (credits_d == max_credits_lp)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pkt            = '0;
        pkt.addr       = base_q + addr_width_p'(idx_q);
        pkt.src_x_cord = my_x_i;
        pkt.src_y_cord = my_y_i;
        pkt.x_cord     = dest_x_i;
        pkt.y_cord     = dest_y_i;
        if (state_q == LOAD) begin
            pkt.op     = e_remote_load;
            pkt.reg_id = 5'(idx_q);
        end else begin
            pkt.op      = e_remote_store;
            pkt.payload = seed_q + data_width_p'(idx_q);
        end
    end

    always_comb begin
        link_out                   = '0;
        link_out.fwd.v             = fwd_v;
        link_out.fwd.data          = pkt;
        link_out.fwd.ready_and_rev = in_rdy;
        link_out.rev.ready_and_rev = in_rdy;
    end

    assign link_sif_o = link_out;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            n_q       <= '0;
            base_q    <= '0;
            seed_q    <= '0;
            idx_q     <= '0;
            st_ret_q  <= '0;
            ld_ret_q  <= '0;
            credits_q <= max_credits_lp;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            base_q    <= base_d;
            seed_q    <= seed_d;
            idx_q     <= idx_d;
            st_ret_q  <= st_ret_d;
            ld_ret_q  <= ld_ret_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign busy_o        = (state_q == STORE) | (state_q == LOAD) | (state_q == DRAIN);
    assign done_o        = (state_q == DONE);
    assign error_count_o = err_q;
    assign credits_o     = credits_q;

endmodule

// File: tb/tb_bsg_manycore_link_traffic_gen.sv
// Scoreboard bench: a loopback memory/return model answers the generator's requests while a
// link monitor checks every sent packet and the credit count against a queue-based model.
module tb_bsg_manycore_link_traffic_gen;

    localparam int AW = 16, DW = 32, XW = 4, YW = 4, CW = 6, MAXC = 16;
    localparam int CRW = $clog2(MAXC + 1);

    localparam logic [3:0] OP_LOAD = 4'd0, OP_STORE = 4'd1;
    localparam logic [1:0] RT_CREDIT = 2'd0, RT_WB = 2'd1;
    localparam logic [XW-1:0] MY_X = 4'h1, DEST_X = 4'h3;
    localparam logic [YW-1:0] MY_Y = 4'h2, DEST_Y = 4'h4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [3:0]    op;
        logic [4:0]    reg_id;
        logic [DW-1:0] payload;
        logic [YW-1:0] src_y;
        logic [XW-1:0] src_x;
        logic [YW-1:0] y_cord;
        logic [XW-1:0] x_cord;
    } pkt_t;

    typedef struct packed {
        logic [1:0]    pkt_type;
        logic [DW-1:0] data;
        logic [4:0]    reg_id;
        logic [YW-1:0] y_cord;
        logic [XW-1:0] x_cord;
    } ret_t;

    typedef struct packed {
        logic fv;
        pkt_t fdata;
        logic fready;
        logic rv;
        ret_t rdata;
        logic rready;
    } sif_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_i = 1'b1;
    sif_t           sif_in, sif_out;
    logic           start_i = 1'b0;
    logic [CW-1:0]  num_pkts_i = '0;
    logic [AW-1:0]  base_addr_i = '0;
    logic [DW-1:0]  seed_i = '0;
    logic           busy_o, done_o;
    logic [CW-1:0]  err_o;
    logic [CRW-1:0] credits_o;

    bsg_manycore_link_traffic_gen #(
        .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
        .max_out_credits_p(MAXC), .count_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .link_sif_i(sif_in), .link_sif_o(sif_out),
        .my_x_i(MY_X), .my_y_i(MY_Y), .dest_x_i(DEST_X), .dest_y_i(DEST_Y),
        .start_i(start_i), .num_pkts_i(num_pkts_i), .base_addr_i(base_addr_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .error_count_o(err_o), .credits_o(credits_o)
    );

    int checks = 0, failures = 0;
    pkt_t exp_fwd[$];
    ret_t pend[$];
    bit [DW-1:0] mem [int];
    int outstanding = 0, sends = 0, v_cycles = 0, load_idx = 0;
    bit stall = 0, rnd_ready = 0, corrupt = 0, inject_fwd = 0, inject_stray = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Link process: returns model, credit model and fwd-packet scoreboard.
    initial begin : link_proc
        ret_t r;
        pkt_t p, e, held;
        int   out_start;
        bit   stalled_prev;
        sif_in = '0;
        stalled_prev = 0;
        held = '0;
        forever begin
            @(negedge clk); #1;
            if (reset_i) begin
                chk("rst_fwd_v", sif_out.fv, 0);
                chk("rst_fwd_in_ready", sif_out.fready, 0);
                chk("rst_rev_ready", sif_out.rready, 0);
                chk("rst_rev_v", sif_out.rv, 0);
                pend.delete();
                outstanding = 0;
                stalled_prev = 0;
                sif_in = '0;
                continue;
            end
            chk("credits", credits_o, MAXC - outstanding);
            chk("rev_ready", sif_out.rready, 1);
            chk("fwd_in_ready", sif_out.fready, 1);
            chk("rev_out_v", sif_out.rv, 0);
            out_start = outstanding;

            sif_in.fready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            sif_in.rv = 1'b0;
            sif_in.rdata = '0;
            if (inject_stray) begin
                sif_in.rv = 1'b1;
                sif_in.rdata.pkt_type = RT_CREDIT;
                inject_stray = 0;
            end else if (!stall && pend.size() > 0 && $urandom_range(0, 3) != 0) begin
                sif_in.rv = 1'b1;
                sif_in.rdata = pend.pop_front();
                outstanding--;
            end
            sif_in.fv = inject_fwd;
            sif_in.fdata = pkt_t'({$urandom, $urandom, $urandom});
            inject_fwd = 0;

            #1;
            if (stalled_prev) begin
                chk("stall_v", sif_out.fv, 1);
                chk("stall_data", sif_out.fdata, held);
            end
            if (out_start == MAXC) chk("v_without_credit", sif_out.fv, 0);
            if (exp_fwd.size() == 0) chk("v_unexpected", sif_out.fv, 0);
            if (sif_out.fv) v_cycles++;
            stalled_prev = sif_out.fv && !sif_in.fready;
            held = sif_out.fdata;

            if (sif_out.fv && sif_in.fready && exp_fwd.size() != 0) begin
                p = sif_out.fdata;
                e = exp_fwd.pop_front();
                if (e.op == OP_LOAD) begin
                    p.payload = '0;
                    e.payload = '0;
                end
                chk("fwd_pkt", p, e);
                sends++;
                r = '0;
                r.x_cord = MY_X;
                r.y_cord = MY_Y;
                if (sif_out.fdata.op == OP_STORE) begin
                    mem[int'(sif_out.fdata.addr)] = sif_out.fdata.payload;
                    r.pkt_type = RT_CREDIT;
                end else begin
                    r.pkt_type = RT_WB;
                    r.reg_id = sif_out.fdata.reg_id;
                    r.data = mem.exists(int'(sif_out.fdata.addr)) ? mem[int'(sif_out.fdata.addr)]
                                                                  : 32'hDEADBEEF;
                    if (corrupt && load_idx == 2) r.data = 32'hFF;
                    load_idx++;
                end
                pend.push_back(r);
                outstanding++;
            end
        end
    end

    task automatic start_run(input int n, input logic [AW-1:0] base, input logic [DW-1:0] seed);
        pkt_t e;
        @(negedge clk);
        for (int i = 0; i < 2 * n; i++) begin
            e = '0;
            e.addr = base + AW'(i % n);
            e.src_x = MY_X;
            e.src_y = MY_Y;
            e.x_cord = DEST_X;
            e.y_cord = DEST_Y;
            if (i < n) begin
                e.op = OP_STORE;
                e.payload = seed + DW'(i);
            end else begin
                e.op = OP_LOAD;
                e.reg_id = 5'((i - n) % 32);
            end
            exp_fwd.push_back(e);
        end
        sends = 0;
        v_cycles = 0;
        load_idx = 0;
        start_i = 1'b1;
        num_pkts_i = CW'(n);
        base_addr_i = base;
        seed_i = seed;
        @(negedge clk);
        start_i = 1'b0;
        num_pkts_i = CW'($urandom);
        base_addr_i = AW'($urandom);
        seed_i = $urandom;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done_o && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_done"}, done_o, 1);
    endtask

    task automatic end_checks(input string name, input int exp_err);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_errors"}, err_o, exp_err);
        chk({name, "_credits"}, credits_o, MAXC);
        chk({name, "_all_sent"}, exp_fwd.size(), 0);
        chk({name, "_outstanding"}, outstanding, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_errors", err_o, 0);
        chk("reset_credits", credits_o, MAXC);
        reset_i = 1'b0;
        @(negedge clk);

        // N=0: done one cycle after start, no traffic.
        chk("n0_pre_done", done_o, 0);
        start_run(0, 16'h0010, 32'h5);
        chk("n0_done_t1", done_o, 1);
        repeat (5) @(negedge clk);
        chk("n0_no_v", v_cycles, 0);
        end_checks("n0", 0);

        start_run(4, 16'h0100, 32'hA0);
        wait_done("basic");
        end_checks("basic", 0);

        corrupt = 1;
        start_run(4, 16'h0100, 32'hA0);
        wait_done("corrupt");
        end_checks("corrupt", 1);
        corrupt = 0;

        // Returns withheld: issue stops once every credit is in flight.
        stall = 1;
        start_run(20, 16'h0400, 32'h1000);
        repeat (40) @(negedge clk);
        chk("stall_sends", sends, MAXC);
        chk("stall_v_low", sif_out.fv, 0);
        chk("stall_credits", credits_o, 0);
        stall = 0;
        wait_done("stall");
        end_checks("stall", 0);

        // Random backpressure, reg_id wrap past 31, and an ignored mid-run start.
        rnd_ready = 1;
        start_run(40, AW'($urandom), $urandom);
        repeat (5) @(negedge clk);
        start_i = 1'b1;
        num_pkts_i = CW'(1);
        @(negedge clk);
        start_i = 1'b0;
        wait_done("random");
        end_checks("random", 0);
        rnd_ready = 0;

        // Dropped fwd packet plus stray return in one cycle, then saturation.
        inject_fwd = 1;
        inject_stray = 1;
        @(negedge clk);
        @(negedge clk);
        chk("double_error", err_o, 2);
        chk("double_error_credits", credits_o, MAXC);
        for (int i = 0; i < 32; i++) begin
            inject_fwd = 1;
            inject_stray = 1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("error_saturate", err_o, (1 << CW) - 1);
        chk("error_done_held", done_o, 1);

        start_run(20, 16'h2000, $urandom);
        k = 0;
        while (sends < 22 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("reached_load", sends >= 22, 1);
        chk("reset_mid_busy_pre", busy_o, 1);
        reset_i = 1'b1;
        exp_fwd.delete();
        @(negedge clk);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_credits", credits_o, MAXC);
        chk("midrst_errors", err_o, 0);
        reset_i = 1'b0;
        start_run(3, 16'h0300, 32'h77);
        wait_done("after_reset");
        end_checks("after_reset", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
